// File: rtl/tcm_dport_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tcm_dport_ctrl_pkg
//  Purpose  : Shared types and constants for the TCM data-port controller
//  Revision : 1.0 - initial release
// ============================================================================
package tcm_dport_ctrl_pkg;

    // Request/response tag width carried through the port.
    localparam int TAG_W = 11;

    // Default byte base address of the TCM window.
    localparam logic [31:0] DEFAULT_TCM_BASE = 32'h0000_0000;

    // Controller states: zero-fill after reset, then normal request service.
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    // Place 32-bit store byte enables into the selected half of the 64-bit word.
    function automatic logic [7:0] lane_wr_mask(input logic lane, input logic [3:0] be);
        return lane ? {be, 4'b0000} : {4'b0000, be};
    endfunction

endpackage
`default_nettype wire

// File: rtl/tcm_dport_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : tcm_dport_ctrl_if
//  Purpose  : LSU-side tagged request/response bus of the TCM data port
//  Revision : 1.0 - initial release
// ============================================================================
interface tcm_dport_ctrl_if;
    import tcm_dport_ctrl_pkg::*;

    // Request side (driven by the LSU)
    logic [31:0]      mem_addr_i;
    logic [31:0]      mem_data_wr_i;
    logic             mem_rd_i;
    logic [3:0]       mem_wr_i;
    logic             mem_cacheable_i;
    logic [TAG_W-1:0] mem_req_tag_i;
    logic             mem_invalidate_i;
    logic             mem_writeback_i;
    logic             mem_flush_i;

    // Response side (driven by the controller)
    logic             mem_accept_o;
    logic             mem_ack_o;
    logic             mem_error_o;
    logic [TAG_W-1:0] mem_resp_tag_o;
    logic [31:0]      mem_data_rd_o;

    // LSU view
    modport master (
        output mem_addr_i, mem_data_wr_i, mem_rd_i, mem_wr_i, mem_cacheable_i,
               mem_req_tag_i, mem_invalidate_i, mem_writeback_i, mem_flush_i,
        input  mem_accept_o, mem_ack_o, mem_error_o, mem_resp_tag_o, mem_data_rd_o
    );

    // Controller view
    modport slave (
        input  mem_addr_i, mem_data_wr_i, mem_rd_i, mem_wr_i, mem_cacheable_i,
               mem_req_tag_i, mem_invalidate_i, mem_writeback_i, mem_flush_i,
        output mem_accept_o, mem_ack_o, mem_error_o, mem_resp_tag_o, mem_data_rd_o
    );

endinterface
`default_nettype wire

// File: rtl/tcm_dport_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tcm_dport_ctrl
//  Purpose  : Core-side controller for one port of the dual-port 64-bit TCM.
//             Converts tagged 32-bit LSU requests into byte-masked 64-bit RAM
//             accesses, returns a tagged response one cycle later, flags
//             out-of-window addresses, and optionally zero-fills the RAM
//             after reset before accepting traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tcm_dport_ctrl
    import tcm_dport_ctrl_pkg::*;
#(
    parameter int          TCM_MEM_SIZE   = 65536,
    parameter logic [31:0] TCM_BASE       = DEFAULT_TCM_BASE,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    localparam int         DEPTH          = TCM_MEM_SIZE / 8,
    localparam int         AW             = $clog2(DEPTH)
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    tcm_dport_ctrl_if.slave    mem,
    output logic [AW-1:0]      ram_addr_o,
    output logic [63:0]        ram_data_wr_o,
    output logic [7:0]         ram_wr_o,
    input  wire logic [63:0]   ram_data_rd_i
);

    localparam logic [31:0]   C_SIZE        = TCM_MEM_SIZE;
    localparam logic [AW-1:0] C_LAST        = AW'(DEPTH - 1);
    localparam logic [AW-1:0] C_ONE         = AW'(1);
    localparam state_t        C_RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    state_t           state_q, state_d;
    logic [AW-1:0]    clr_cnt_q, clr_cnt_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             lane_q, lane_d;
    logic             rd_q, rd_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    // Address decode relative to the TCM window.
    logic [31:0] w_off;
    logic        w_in_range;
    logic        w_lane;
    logic        w_store;
    logic        w_maint;
    logic        w_valid;
    logic        w_unused;

    assign w_off      = mem.mem_addr_i - TCM_BASE;
    assign w_in_range = (w_off < C_SIZE);
    assign w_lane     = w_off[2];
    assign w_store    = |mem.mem_wr_i;
    assign w_maint    = mem.mem_invalidate_i | mem.mem_writeback_i | mem.mem_flush_i;
    assign w_valid    = mem.mem_rd_i | w_store | w_maint;

    // Cacheability hint and byte offset inside a word carry no meaning here.
    assign w_unused = ^{mem.mem_cacheable_i, w_off[31:AW+3], w_off[1:0]};

    // Next-state, RAM drive and response capture for the clear/idle FSM.
    always_comb begin
        state_d          = state_q;
        clr_cnt_d        = clr_cnt_q;
        ack_d            = 1'b0;
        err_d            = 1'b0;
        rd_d             = 1'b0;
        lane_d           = lane_q;
        tag_d            = tag_q;
        mem.mem_accept_o = 1'b0;
        ram_addr_o       = w_off[AW+2:3];
        ram_data_wr_o    = {mem.mem_data_wr_i, mem.mem_data_wr_i};
        ram_wr_o         = 8'h00;

        case (state_q)
            ST_CLEAR: begin
                // Reset holds the state here; keep the RAM untouched until release.
                ram_addr_o    = clr_cnt_q;
                ram_data_wr_o = 64'h0;
                ram_wr_o      = rst_i ? 8'h00 : 8'hFF;
                clr_cnt_d     = clr_cnt_q + C_ONE;
                if (clr_cnt_q == C_LAST) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = '0;
                end
            end

            ST_IDLE: begin
                mem.mem_accept_o = 1'b1;
                if (w_valid) begin
                    ack_d  = 1'b1;
                    tag_d  = mem.mem_req_tag_i;
                    lane_d = w_lane;
                    // Any load/store decodes the address; a pure maintenance op
                    // never touches the RAM and never errors.
                    if (mem.mem_rd_i || w_store) begin
                        if (w_in_range) begin
                            rd_d = mem.mem_rd_i;
                            if (w_store) begin
                                ram_wr_o = lane_wr_mask(w_lane, mem.mem_wr_i);
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = C_RESET_STATE;
            end
        endcase
    end

    // State, clear counter and one-cycle response registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= C_RESET_STATE;
            clr_cnt_q <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            lane_q    <= 1'b0;
            rd_q      <= 1'b0;
            tag_q     <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            lane_q    <= lane_d;
            rd_q      <= rd_d;
            tag_q     <= tag_d;
        end
    end

    // Response outputs; load data comes straight from the RAM's output register.
    assign mem.mem_ack_o      = ack_q;
    assign mem.mem_error_o    = err_q;
    assign mem.mem_resp_tag_o = tag_q;
    assign mem.mem_data_rd_o  = (ack_q & rd_q & ~err_q)
                              ? (lane_q ? ram_data_rd_i[63:32] : ram_data_rd_i[31:0])
                              : 32'h0;

endmodule
`default_nettype wire
